coin_spawner: RTL and testbench

- Upstream feeder of the coin-collision stage: owns the on-screen coin position.
- Scrolls the coin left once per frame tick and respawns it at the right edge with a pseudo-random height.
- Hides the coin on collection; freezes on game over.
- Drives the coin left/right X edges and top Y consumed by the collision stage, plus a visibility flag and a collected-coin count.

---
 rtl/coin_spawner_pkg.sv | 24 ++
 rtl/coin_spawner_lfsr16.sv | 17 +
 rtl/coin_spawner.sv | 145 ++++++++++++++
 tb/tb_coin_spawner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/coin_spawner_pkg.sv
// Shared definitions for the coin spawner and the coin-collision stage:
// FSM states, screen size, coin geometry defaults and the LFSR tap mask.
package coin_spawner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HIDDEN,
    ST_FREEZE
  } state_t;

  localparam int unsigned SCREEN_W        = 640;
  localparam int unsigned SCREEN_H        = 480;
  localparam int unsigned DEF_COIN_WIDTH  = 20;
  localparam int unsigned DEF_COIN_HEIGHT = 20;

  // Fibonacci taps 16,14,13,11 -> bit indices 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [9:0] left_edge(input logic [9:0] right, input logic [9:0] width);
    return (right >= width) ? right - width : '0;
  endfunction

endpackage

// File: rtl/coin_spawner_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used for the coin respawn height.
module lfsr16
  import coin_spawner_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        reset,
  output logic [15:0] value
);

  always_ff @(posedge Clk) begin
    if (reset) value <= SEED;
    else       value <= {value[14:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/coin_spawner.sv
// Coin position owner: scrolls, respawns, hides on collection, freezes on game over.
// Build with COIN_SPEEDUP_EN defined to make the scroll step grow with coin_count.
module coin_spawner
  import coin_spawner_pkg::*;
#(
  parameter int unsigned SPAWN_X     = 660,
  parameter int unsigned COIN_WIDTH  = DEF_COIN_WIDTH,
  parameter int unsigned COIN_HEIGHT = DEF_COIN_HEIGHT,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned Y_MIN       = 100,
  parameter int unsigned HIDE_TICKS  = 30,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       frame_tick,
  input  logic       game_over,
  input  logic       get_coin,
  output logic [9:0] X_Coin_L,
  output logic [9:0] X_Coin_R,
  output logic [9:0] Y_Coin,
  output logic       coin_visible,
  output logic [7:0] coin_count
);

  localparam logic [9:0]  SPAWN_X10 = 10'(SPAWN_X);
  localparam logic [9:0]  WIDTH10   = 10'(COIN_WIDTH);
  localparam logic [9:0]  Y_MIN10   = 10'(Y_MIN);
  localparam logic [9:0]  SPAWN_L   = left_edge(SPAWN_X10, WIDTH10);
  localparam int unsigned HW        = $clog2(HIDE_TICKS + 1);
  localparam logic [HW-1:0] HIDE_LAST = HW'(HIDE_TICKS - 1);

  if (LFSR_SEED == 16'd0 || SPAWN_X < SCREEN_W || HIDE_TICKS == 0 ||
      Y_MIN + 255 + COIN_HEIGHT > SCREEN_H) begin : g_bad_params
    $error("coin_spawner: invalid parameter set");
  end

  state_t        state;
  logic [HW-1:0] hide_cnt;
  logic          get_coin_q;
  logic          coin_rise;
  logic [15:0]   lfsr;
  logic [9:0]    step;
  logic [9:0]    x_scroll;
  logic          wrap;
  logic          unused_lfsr_hi;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk   (Clk),
    .reset (reset),
    .value (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:8];
  assign coin_rise      = get_coin & ~get_coin_q;

`ifdef COIN_SPEEDUP_EN
  logic [5:0] step_raw;
  assign step_raw = 6'(SPEED) + {1'b0, coin_count[7:3]};
  assign step     = (step_raw > 6'd8) ? 10'd8 : {4'b0, step_raw};
`else
  assign step = 10'(SPEED);
`endif

  assign wrap     = (X_Coin_R <= step);
  assign x_scroll = X_Coin_R - step;

  always_ff @(posedge Clk) begin
    get_coin_q <= get_coin;
    if (reset) begin
      state        <= ST_IDLE;
      X_Coin_R     <= SPAWN_X10;
      X_Coin_L     <= SPAWN_L;
      Y_Coin       <= Y_MIN10;
      coin_visible <= 1'b0;
      coin_count   <= '0;
      hide_cnt     <= '0;
      get_coin_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (Start) begin
            X_Coin_R     <= SPAWN_X10;
            X_Coin_L     <= SPAWN_L;
            Y_Coin       <= Y_MIN10 + {2'b0, lfsr[7:0]};
            coin_visible <= 1'b1;
            coin_count   <= '0;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (game_over) begin
            state <= ST_FREEZE;
          end else if (coin_rise && coin_visible) begin
            coin_count   <= coin_count + 8'd1;
            coin_visible <= 1'b0;
            hide_cnt     <= '0;
            state        <= ST_HIDDEN;
          end else if (frame_tick) begin
            if (wrap) begin
              X_Coin_R     <= SPAWN_X10;
              X_Coin_L     <= SPAWN_L;
              Y_Coin       <= Y_MIN10 + {2'b0, lfsr[7:0]};
              coin_visible <= 1'b1;
            end else begin
              X_Coin_R <= x_scroll;
              X_Coin_L <= left_edge(x_scroll, WIDTH10);
            end
          end
        end
        ST_HIDDEN: begin
          if (game_over) begin
            state <= ST_FREEZE;
          end else if (frame_tick) begin
            if (hide_cnt == HIDE_LAST) begin
              X_Coin_R     <= SPAWN_X10;
              X_Coin_L     <= SPAWN_L;
              Y_Coin       <= Y_MIN10 + {2'b0, lfsr[7:0]};
              coin_visible <= 1'b1;
              state        <= ST_RUN;
            end else begin
              hide_cnt <= hide_cnt + 1'b1;
              // A hidden coin that scrolls off the left edge wraps but stays hidden
              X_Coin_R <= wrap ? SPAWN_X10 : x_scroll;
              X_Coin_L <= wrap ? SPAWN_L : left_edge(x_scroll, WIDTH10);
            end
          end
        end
        ST_FREEZE: begin
          if (Ack) begin
            X_Coin_R     <= SPAWN_X10;
            X_Coin_L     <= SPAWN_L;
            Y_Coin       <= Y_MIN10;
            coin_visible <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_spawner.sv
// Self-checking bench for coin_spawner: directed scenarios plus random traffic
// against a behavioural model of the coin's game rules.
module tb_coin_spawner;

  localparam int          SPAWN   = 660;
  localparam int          WIDTH   = 20;
  localparam int          SPEED   = 2;
  localparam int          YMIN    = 100;
  localparam int          HIDE    = 30;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic       Clk = 1'b0;
  logic       reset = 1'b1, Start = 1'b0, Ack = 1'b0;
  logic       frame_tick = 1'b0, game_over = 1'b0, get_coin = 1'b0;
  logic [9:0] X_Coin_L, X_Coin_R, Y_Coin;
  logic       coin_visible;
  logic [7:0] coin_count;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  // Behavioural model
  string       m_phase;
  int          m_x, m_y, m_cnt, m_hidden_ticks;
  bit          m_vis, m_prev_gc;
  logic [15:0] m_lfsr;

  coin_spawner dut (
    .Clk          (Clk),
    .reset        (reset),
    .Start        (Start),
    .Ack          (Ack),
    .frame_tick   (frame_tick),
    .game_over    (game_over),
    .get_coin     (get_coin),
    .X_Coin_L     (X_Coin_L),
    .X_Coin_R     (X_Coin_R),
    .Y_Coin       (Y_Coin),
    .coin_visible (coin_visible),
    .coin_count   (coin_count)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int cur_step();
    int s;
    s = SPEED;
`ifdef COIN_SPEEDUP_EN
    s = SPEED + m_cnt / 8;
    if (s > 8) s = 8;
`endif
    return s;
  endfunction

  task automatic respawn();
    m_x   = SPAWN;
    m_y   = YMIN + int'(m_lfsr & 16'h00FF);
    m_vis = 1;
  endtask

  task automatic model_clock();
    bit rise;
    int s;
    rise = get_coin && !m_prev_gc;
    s    = cur_step();
    if (reset) begin
      m_phase = "idle"; m_x = SPAWN; m_y = YMIN; m_vis = 0; m_cnt = 0;
      m_lfsr = SEED; m_hidden_ticks = 0; m_prev_gc = 0;
      return;
    end
    if (m_phase == "idle") begin
      if (Start) begin respawn(); m_cnt = 0; m_phase = "run"; end
    end else if (m_phase == "run") begin
      if (game_over) m_phase = "freeze";
      else if (rise && m_vis) begin
        m_cnt = (m_cnt + 1) % 256; m_vis = 0; m_hidden_ticks = 0; m_phase = "hidden";
      end else if (frame_tick) begin
        if (m_x <= s) respawn(); else m_x -= s;
      end
    end else if (m_phase == "hidden") begin
      if (game_over) m_phase = "freeze";
      else if (frame_tick) begin
        m_hidden_ticks++;
        if (m_hidden_ticks == HIDE) begin respawn(); m_phase = "run"; end
        else m_x = (m_x <= s) ? SPAWN : m_x - s;
      end
    end else if (m_phase == "freeze") begin
      if (Ack) begin m_x = SPAWN; m_y = YMIN; m_vis = 0; m_phase = "idle"; end
    end
    m_lfsr    = lfsr_next(m_lfsr);
    m_prev_gc = get_coin;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_clock();
    #1;
    chk("x_right", 32'(X_Coin_R), m_x);
    chk("x_left", 32'(X_Coin_L), (m_x >= WIDTH) ? m_x - WIDTH : 0);
    chk("y_top", 32'(Y_Coin), m_y);
    chk("visible", 32'(coin_visible), 32'(m_vis));
    chk("count", 32'(coin_count), m_cnt);
  endtask

  task automatic tick();
    frame_tick = 1'b1; cyc();
    frame_tick = 1'b0; cyc();
  endtask

  initial begin
    int x_before, cnt_before, freeze_x, freeze_y;

    // Reset and start
    reset = 1'b1; cyc(); cyc();
    chk("reset_x", 32'(X_Coin_R), SPAWN);
    chk("reset_vis", 32'(coin_visible), 0);
    reset = 1'b0; Start = 1'b1; cyc(); Start = 1'b0;
    chk("start_vis", 32'(coin_visible), 1);
    chk("start_xl", 32'(X_Coin_L), SPAWN - WIDTH);
    chk("start_y", 32'(Y_Coin), YMIN + int'(SEED & 16'h00FF));

    // Full traverse and respawn
    for (int i = 0; i < 330; i++) begin
      tick();
      if (i == 328) begin
        chk("min_x", 32'(X_Coin_R), 2);
        chk("min_xl_sat", 32'(X_Coin_L), 0);
      end
    end
    chk("respawn_x", 32'(X_Coin_R), SPAWN);

    // Held collection at x=400
    for (int i = 0; i < 200 && m_x != 400; i++) tick();
    chk("at_400", 32'(X_Coin_R), 400);
    get_coin = 1'b1; cyc();
    chk("collect_cnt", 32'(coin_count), 1);
    chk("collect_hide", 32'(coin_visible), 0);
    for (int i = 0; i < HIDE; i++) begin
      if (i == HIDE - 1) chk("still_hidden", 32'(coin_visible), 0);
      tick();
    end
    chk("reappear_vis", 32'(coin_visible), 1);
    chk("reappear_x", 32'(X_Coin_R), SPAWN);
    chk("held_no_recount", 32'(coin_count), 1);
    get_coin = 1'b0; cyc(); tick(); tick();

    // Collection and frame tick in the same cycle
    x_before = m_x;
    get_coin = 1'b1; frame_tick = 1'b1; cyc();
    get_coin = 1'b0; frame_tick = 1'b0;
    chk("same_cycle_x", 32'(X_Coin_R), x_before);
    chk("same_cycle_cnt", 32'(coin_count), 2);
    for (int i = 0; i < HIDE; i++) tick();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      get_coin   = ($urandom_range(0, 5) == 0) ? ~get_coin : get_coin;
      cyc();
    end
    frame_tick = 1'b0; get_coin = 1'b0; cyc();

    // Freeze on game over
    for (int i = 0; i < 200 && m_phase != "run"; i++) tick();
    chk("run_before_freeze", 32'(coin_visible), 1);
    tick();
    freeze_x = m_x; freeze_y = m_y; cnt_before = m_cnt;
    game_over = 1'b1; frame_tick = 1'b1; get_coin = 1'b1; cyc();
    for (int i = 0; i < 100; i++) begin
      get_coin = $urandom_range(0, 1);
      Start    = $urandom_range(0, 1);
      tick();
    end
    Start = 1'b0; get_coin = 1'b0;
    chk("freeze_x", 32'(X_Coin_R), freeze_x);
    chk("freeze_y", 32'(Y_Coin), freeze_y);
    chk("freeze_cnt", 32'(coin_count), cnt_before);
    game_over = 1'b0; Ack = 1'b1; cyc(); Ack = 1'b0;
    chk("ack_vis", 32'(coin_visible), 0);
    chk("ack_x", 32'(X_Coin_R), SPAWN);
    chk("ack_cnt_held", 32'(coin_count), cnt_before);
    tick();
    Start = 1'b1; cyc(); Start = 1'b0;
    chk("start_clears_cnt", 32'(coin_count), 0);

    // Collect 16 coins, then measure the step
    for (int n = 0; n < 16; n++) begin
      get_coin = 1'b1; cyc();
      get_coin = 1'b0; cyc();
      for (int i = 0; i < HIDE; i++) tick();
    end
    chk("cnt16", 32'(coin_count), 16);
    chk("cnt16_x", 32'(X_Coin_R), SPAWN);
    x_before = SPAWN;
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
`ifdef COIN_SPEEDUP_EN
    chk("speed_step", 32'(x_before - int'(X_Coin_R)), 4);
`else
    chk("speed_step", 32'(x_before - int'(X_Coin_R)), 2);
`endif

    // Reset while hidden
    get_coin = 1'b1; cyc(); get_coin = 1'b0;
    tick(); tick();
    chk("hidden_before_reset", 32'(coin_visible), 0);
    reset = 1'b1; frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    chk("rst_x", 32'(X_Coin_R), SPAWN);
    chk("rst_xl", 32'(X_Coin_L), SPAWN - WIDTH);
    chk("rst_y", 32'(Y_Coin), YMIN);
    chk("rst_vis", 32'(coin_visible), 0);
    chk("rst_cnt", 32'(coin_count), 0);
    reset = 1'b0; Start = 1'b1; cyc(); Start = 1'b0;
    chk("rst_reseed_y", 32'(Y_Coin), YMIN + int'(SEED & 16'h00FF));
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
